// File: rtl/n_bit_alu_pkg.sv
// Shared definitions for the n-bit ALU: select encodings and their width.
package alu_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_ADD = 2'b10,
        SEL_SLT = 2'b11
    } sel_e;

endpackage

// File: rtl/n_bit_alu_if.sv
// Operand/control and result/flag bundle between the execute-stage muxes and the ALU.
interface n_bit_alu_if
    import alu_pkg::*;
#(
    parameter int n = 32
);
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic             cin;
    logic             ainv;
    logic             binv;
    logic [SEL_W-1:0] select;
    logic [n-1:0]     result;
    logic             cout;
    logic             zero;
    logic             overflow;

    modport master (
        output a, b, cin, ainv, binv, select,
        input  result, cout, zero, overflow
    );

    modport slave (
        input  a, b, cin, ainv, binv, select,
        output result, cout, zero, overflow
    );
endinterface

// File: rtl/n_bit_alu_bit_slice.sv
// One bit of the ripple-carry ALU. Select 11 returns "less" when ALU_SLT_EN
// is defined, otherwise the XOR of the effective operands.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic             a,
    input  logic             b,
    input  logic             ainv,
    input  logic             binv,
    input  logic             carry_in,
    input  logic             less,
    input  logic [SEL_W-1:0] select,
    output logic             res,
    output logic             carry_out,
    output logic             sum,
    output logic             overflow
);
    logic aa;
    logic bb;

    assign aa        = ainv ? ~a : a;
    assign bb        = binv ? ~b : b;
    assign sum       = aa ^ bb ^ carry_in;
    assign carry_out = (aa & bb) | (carry_in & (aa ^ bb));
    // Only meaningful in the MSB slice: carry into vs. out of the sign bit.
    assign overflow  = carry_in ^ carry_out;

`ifndef ALU_SLT_EN
    logic unused_less;
    assign unused_less = less;
`endif

    // Per-bit result mux.
    always_comb begin
        res = 1'b0;
        case (sel_e'(select))
            SEL_AND: res = aa & bb;
            SEL_OR:  res = aa | bb;
            SEL_ADD: res = sum;
`ifdef ALU_SLT_EN
            SEL_SLT: res = less;
`else
            SEL_SLT: res = aa ^ bb;
`endif
            default: res = 1'b0;
        endcase
    end
endmodule

// File: rtl/n_bit_alu.sv
// n-bit ripple-carry ALU with registered result and flags (one-cycle latency).
// Optional macro ALU_SLT_EN: select 11 is set-less-than; otherwise XOR.
module n_bit_alu
    import alu_pkg::*;
#(
    parameter int n = 32
)(
    input  logic         clk,
    input  logic         rst_n,
    n_bit_alu_if.slave   bus
);
    logic [n:0]   carry;
    logic [n-1:0] result_d;
    logic [n-1:0] result_q;
    logic         cout_d, cout_q;
    logic         ovf_d, ovf_q;
    logic         zero_d, zero_q;
    logic         msb_sum;
    logic         msb_ovf;
    logic         set_lt;
    logic         arith;

    assign carry[0] = bus.cin;

`ifdef ALU_SLT_EN
    assign set_lt = msb_sum ^ msb_ovf;
    assign arith  = (bus.select == SEL_ADD) || (bus.select == SEL_SLT);
`else
    logic unused_msb_sum;
    assign unused_msb_sum = msb_sum;
    assign set_lt = 1'b0;
    assign arith  = (bus.select == SEL_ADD);
`endif

    for (genvar i = 0; i < n; i++) begin : g_slice
        if (i == n - 1) begin : g_msb
            alu_bit_slice u_slice (
                .a        (bus.a[i]),
                .b        (bus.b[i]),
                .ainv     (bus.ainv),
                .binv     (bus.binv),
                .carry_in (carry[i]),
                .less     (1'b0),
                .select   (bus.select),
                .res      (result_d[i]),
                .carry_out(carry[i+1]),
                .sum      (msb_sum),
                .overflow (msb_ovf)
            );
        end else begin : g_lsb
            logic unused_sum;
            logic unused_ovf;
            alu_bit_slice u_slice (
                .a        (bus.a[i]),
                .b        (bus.b[i]),
                .ainv     (bus.ainv),
                .binv     (bus.binv),
                .carry_in (carry[i]),
                .less     ((i == 0) ? set_lt : 1'b0),
                .select   (bus.select),
                .res      (result_d[i]),
                .carry_out(carry[i+1]),
                .sum      (unused_sum),
                .overflow (unused_ovf)
            );
        end
    end

    // Flags: carry/overflow only reported for arithmetic selects.
    always_comb begin
        cout_d = arith ? carry[n] : 1'b0;
        ovf_d  = arith ? msb_ovf : 1'b0;
        zero_d = ~|result_d;
    end

    // Output registers; reset shows a cleared, zero-flagged result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_n_bit_alu.sv
// Self-checking bench for n_bit_alu (n=32): directed plan plus random
// stimulus against an arithmetic reference model.
module tb_n_bit_alu;
    import alu_pkg::*;

    localparam int N = 32;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    n_bit_alu_if #(.n(N)) bus ();

    n_bit_alu #(.n(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: signed/unsigned arithmetic on the effective operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic ainv, input logic binv, input logic [1:0] sel);
        logic [N-1:0] aa, bb;
        logic [N:0]   usum;
        longint       ssum;
        logic         ovf, slt;
        aa   = ainv ? ~a : a;
        bb   = binv ? ~b : b;
        usum = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, cin};
        ssum = longint'($signed(aa)) + longint'($signed(bb)) + longint'(cin);
        ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        slt  = (ssum < 0);
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        case (sel)
            2'b00: exp_res = aa & bb;
            2'b01: exp_res = aa | bb;
            2'b10: begin
                exp_res  = usum[N-1:0];
                exp_cout = usum[N];
                exp_ovf  = ovf;
            end
            default: begin
`ifdef ALU_SLT_EN
                exp_res  = {{(N-1){1'b0}}, slt};
                exp_cout = usum[N];
                exp_ovf  = ovf;
`else
                exp_res  = aa ^ bb;
`endif
            end
        endcase
        exp_zero = (exp_res == '0);
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic ainv, input logic binv, input logic [1:0] sel);
        @(negedge clk);
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        bus.ainv   = ainv;
        bus.binv   = binv;
        bus.select = sel;
    endtask

    // Drive at negedge, sample 1 after the next rising edge, compare to model.
    task automatic step(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic ainv, input logic binv, input logic [1:0] sel);
        drive(a, b, cin, ainv, binv, sel);
        @(posedge clk);
        #1;
        model(a, b, cin, ainv, binv, sel);
        chk({tag, ".result"}, bus.result, exp_res);
        chk({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
        chk({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
        chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b10);
        #1;
        chk("rst.result", bus.result, 32'd0);
        chk("rst.zero", {31'd0, bus.zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.result", bus.result, 32'd11);

        // Asynchronous assert mid-cycle, away from any edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.result", bus.result, 32'd0);
        chk("arst.cout", {31'd0, bus.cout}, 32'd0);
        chk("arst.ovf", {31'd0, bus.overflow}, 32'd0);
        chk("arst.zero", {31'd0, bus.zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        step("and", 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("and.const", bus.result, 32'd4);
        step("or", 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("or.const", bus.result, 32'd7);
        step("nor", 32'd5, 32'd6, 1'b0, 1'b1, 1'b1, 2'b00);
        chk("nor.const", bus.result, 32'hFFFF_FFF8);
        step("sub", 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 2'b10);
        chk("sub.const", bus.result, 32'hFFFF_FFFF);
        chk("sub.cout", {31'd0, bus.cout}, 32'd0);
        step("subz", 32'd6, 32'd6, 1'b1, 1'b0, 1'b1, 2'b10);
        chk("subz.const", bus.result, 32'd0);
        chk("subz.cout", {31'd0, bus.cout}, 32'd1);
        chk("subz.zero", {31'd0, bus.zero}, 32'd1);
        step("ovfp", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("ovfp.const", bus.result, 32'h8000_0000);
        chk("ovfp.ovf", {31'd0, bus.overflow}, 32'd1);
        step("ovfn", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("ovfn.cout", {31'd0, bus.cout}, 32'd1);
        chk("ovfn.ovf", {31'd0, bus.overflow}, 32'd1);
        chk("ovfn.zero", {31'd0, bus.zero}, 32'd1);
`ifdef ALU_SLT_EN
        step("slt1", 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("slt1.const", bus.result, 32'd1);
        step("slt0", 32'd6, 32'd5, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("slt0.const", bus.result, 32'd0);
        step("sltov", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("sltov.const", bus.result, 32'd1);
`else
        step("xor", 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b11);
        chk("xor.const", bus.result, 32'd3);
        chk("xor.cout", {31'd0, bus.cout}, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) rb = ra;
            step("rand", ra, rb, 1'(($urandom)), 1'($urandom), 1'($urandom), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/n_bit_alu.md
Name: n_bit_alu

Overview:
- Parameterised n-bit ripple-carry ALU in MIPS bit-slice style.
- Operand inversion controls (ainv, binv) plus carry-in give AND, OR, NOR, ADD, SUB and set-less-than.
- Result and flags are registered: one-cycle latency.
- Sits in the datapath execute stage, fed directly by operand muxes.

Parameters:
- n, 32, operand/result width in bits (n >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  n  operand A
- b  input  n  operand B
- cin  input  1  carry into bit 0 (1 with binv=1 forms two's-complement subtract)
- ainv  input  1  invert A before the operation
- binv  input  1  invert B before the operation
- select  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SLT
- result  output  n  registered result
- cout  output  1  registered carry out of bit n-1
- zero  output  1  registered, 1 when result == 0
- overflow  output  1  registered signed overflow

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: asserting rst_n=0 immediately forces result=0, cout=0, overflow=0, zero=1, independent of clk. Deassertion is taken synchronously by the next rising edge.
- Effective operands:
  - aa = ainv ? ~a : a
  - bb = binv ? ~b : b
- Adder: {c_n, sum} = aa + bb + cin, an (n+1)-bit ripple through the bit slices.
- Signed overflow: ovf_raw = (aa[n-1] == bb[n-1]) && (sum[n-1] != aa[n-1]).
- Next-state result by select:
  - 00: aa & bb. ainv=binv=1 yields NOR.
  - 01: aa | bb. ainv=binv=1 yields NAND.
  - 10: sum.
  - 11: {(n-1)'b0, sum[n-1] ^ ovf_raw}. This is a signed a<b only when binv=1 and cin=1; other control settings are legal and produce the same formula.
- Flags:
  - cout = c_n for select 10/11, else 0.
  - overflow = ovf_raw for select 10/11, else 0.
  - zero = (next result == 0).
- All four outputs load on every rising clk edge once out of reset; there is no enable.
- Latency: inputs applied before edge k appear on outputs after edge k.
- Arithmetic wraps modulo 2^n. Carry and overflow are reported, never saturated.
- X or Z on select gives unspecified outputs; no protection logic.

Optional Feature:
- Macro ALU_SLT_EN.
- Defined: select 11 = set-less-than as above.
- Not defined: select 11 = aa ^ bb (XOR); cout=0 and overflow=0 for select 11; zero still computed.
- The slice's "less" input is tied to 0 when not defined.

Decomposition:
- Package alu_pkg:
  - select encodings SEL_AND=2'b00, SEL_OR=2'b01, SEL_ADD=2'b10, SEL_SLT=2'b11
  - localparam width of select
- Sub-module alu_bit_slice, one per bit, generated n times:
  - inputs a, b, ainv, binv, carry_in, less, select
  - outputs res, carry_out
  - The MSB slice additionally exports sum and overflow for SLT.
- Top level contains the generate loop, the zero-detect reduction NOR, and the output registers.

Test Plan:
- Reset: hold rst_n=0 mid-operation with a=5, b=6 -> outputs immediately result=0, cout=0, overflow=0, zero=1. Release rst_n -> first edge loads new values.
- Logic ops, n=32, a=5, b=6, ainv=0, binv=0:
  - select=00 -> result=4
  - select=01 -> result=7
  - ainv=1, binv=1, select=00 -> 0xFFFFFFF8
  - All three: cout=0, overflow=0.
- Subtract: a=5, b=6, cin=1, binv=1, ainv=0, select=10 -> result=0xFFFFFFFF, cout=0, overflow=0, zero=0, one cycle after inputs.
- Zero/carry: a=6, b=6, cin=1, binv=1, select=10 -> result=0, cout=1, zero=1.
- Overflow: a=0x7FFFFFFF, b=1, cin=0, binv=0, select=10 -> result=0x80000000, overflow=1, cout=0. a=0x80000000, b=0x80000000 -> result=0, cout=1, overflow=1, zero=1.
- SLT (ALU_SLT_EN defined), binv=1, cin=1, select=11:
  - a=5, b=6 -> result=1
  - a=6, b=5 -> 0
  - a=0x80000000, b=1 -> 1 (overflow case handled)
  - Without the macro: a=5, b=6, ainv=0, binv=0 -> result=3.
